pls_fp_adder: RTL and testbench
===============================

PLS_FP_ADDER -- requirements
Module: pls_fp_adder

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, operand/result width; only 32 (IEEE-754 single) is supported.
REQ-002 SHALL have port aclk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port areset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports s_a_tdata in 32, s_a_tvalid in 1, s_a_tready out 1: operand A AXI-Stream slave.
REQ-005 SHALL have ports s_b_tdata in 32, s_b_tvalid in 1, s_b_tready out 1: operand B AXI-Stream slave.
REQ-006 SHALL have ports m_result_tdata out 32, m_result_tvalid out 1, m_result_tready in 1: sum A+B AXI-Stream master.

Function
REQ-007 SHALL join operands: one A and one B beat are consumed together; s_a_tready = s_b_tready = s_a_tvalid & s_b_tvalid & advance.
REQ-008 SHALL not consume either operand unless both are valid in the same cycle.
REQ-009 SHALL implement a 4-stage pipeline (unpack/compare-swap, align with guard/round/sticky, add/subtract + leading-zero normalize, round/pack) with a valid bit per stage.
REQ-010 SHALL deliver the result 4 cycles after the accepting handshake when m_result_tready is held high.
REQ-011 SHALL sustain one result per cycle under continuous valid/ready.
REQ-012 SHALL stall all stages while m_result_tvalid=1 and m_result_tready=0 (advance = ~m_result_tvalid | m_result_tready); bubbles are not collapsed.
REQ-013 SHALL hold m_result_tdata stable while m_result_tvalid=1 and not accepted.
REQ-014 SHALL preserve operand order; no result dropped or duplicated.
REQ-015 SHALL round to nearest, ties to even.
REQ-016 SHALL flush denormal inputs to zero of the same sign and flush underflowed results to signed zero.
REQ-017 SHALL return canonical NaN 0x7FC00000 for any NaN input or for +Inf + -Inf.
REQ-018 SHALL return Inf of the Inf operand's sign for Inf + finite, and signed Inf on exponent overflow after rounding.
REQ-019 SHALL return +0 for exact cancellation of nonzero operands; -0 + -0 = -0; +0 + -0 = +0.
REQ-020 SHALL handle exponent difference >= 26 by treating the smaller operand as sticky only.

Reset
REQ-021 SHALL, on areset=1, immediately clear all stage valid bits; m_result_tvalid=0, s_a_tready=0, s_b_tready=0, m_result_tdata=0.
REQ-022 SHALL discard in-flight operations on reset mid-operation; no result from before reset appears afterwards.
REQ-023 SHALL accept new operands on the first clock edge after areset is released.

Configuration
REQ-024 SHALL, with macro PLS_FP_ADDER_SKID_EN defined, insert a 2-entry output skid buffer so that s_*_tready and the stage enables are registered and never combinationally depend on m_result_tready; latency becomes 5 cycles.
REQ-025 SHALL, without PLS_FP_ADDER_SKID_EN, use the direct stall of REQ-012 with 4-cycle latency.
REQ-026 SHALL produce identical result sequences with or without the macro.

Verification
REQ-027 SHALL cover: A=0x3F800000, B=0x40000000, ready=1 -> 0x40400000 exactly 4 cycles (5 with skid) after handshake.
REQ-028 SHALL cover: A=0x3F800000, B=0x33800000 -> 0x3F800000 (tie to even); B=0x33800001 -> 0x3F800001.
REQ-029 SHALL cover: 0x3F800000 + 0xBF800000 -> 0x00000000; 0x7F800000 + 0xFF800000 -> 0x7FC00000; 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
REQ-030 SHALL cover: A valid without B for 5 cycles -> no handshake, s_a_tready=0; B arrives -> both accepted same cycle.
REQ-031 SHALL cover: 20 streamed pairs with m_result_tready low for 10 cycles mid-stream -> all 20 results in order, tdata stable while stalled.
REQ-032 SHALL cover: areset asserted with 3 operations in flight -> m_result_tvalid=0 at once, no stale results after release, next pair 0x40000000+0x40000000 -> 0x40800000.

Source files
------------

// File: rtl/pls_fp_adder.sv
// rtl/pls_fp_adder.sv - IEEE-754 single-precision pipelined adder; optional output skid buffer via PLS_FP_ADDER_SKID_EN
module pls_fp_adder #(
    parameter int DATA_SIZE = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [DATA_SIZE-1:0] s_a_tdata,
    input  logic                 s_a_tvalid,
    output logic                 s_a_tready,
    input  logic [DATA_SIZE-1:0] s_b_tdata,
    input  logic                 s_b_tvalid,
    output logic                 s_b_tready,
    output logic [DATA_SIZE-1:0] m_result_tdata,
    output logic                 m_result_tvalid,
    input  logic                 m_result_tready
);

    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic advance;
    logic take;

    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;

    assign {sa, ea, fa} = s_a_tdata;
    assign {sb, eb, fb} = s_b_tdata;

    // stage 1: unpack, classify, swap so the larger magnitude is "big"
    logic        s1_valid_q, s1_valid_d;
    logic        s1_spec_q, s1_spec_d;
    logic [31:0] s1_spec_val_q, s1_spec_val_d;
    logic        s1_sign_q, s1_sign_d;
    logic        s1_sub_q, s1_sub_d;
    logic [7:0]  s1_exp_q, s1_exp_d;
    logic [7:0]  s1_diff_q, s1_diff_d;
    logic [23:0] s1_mbig_q, s1_mbig_d;
    logic [23:0] s1_msmall_q, s1_msmall_d;

    // stage 2: aligned mantissas with guard/round/sticky
    logic        s2_valid_q, s2_valid_d;
    logic        s2_spec_q, s2_spec_d;
    logic [31:0] s2_spec_val_q, s2_spec_val_d;
    logic        s2_sign_q, s2_sign_d;
    logic        s2_sub_q, s2_sub_d;
    logic [7:0]  s2_exp_q, s2_exp_d;
    logic [26:0] s2_mbig_q, s2_mbig_d;
    logic [26:0] s2_msmall_q, s2_msmall_d;

    // stage 3: normalized sum, exponent kept signed-wide to catch underflow
    logic        s3_valid_q, s3_valid_d;
    logic        s3_spec_q, s3_spec_d;
    logic [31:0] s3_spec_val_q, s3_spec_val_d;
    logic        s3_sign_q, s3_sign_d;
    logic        s3_zero_q, s3_zero_d;
    logic [9:0]  s3_exp_q, s3_exp_d;
    logic [26:0] s3_mant_q, s3_mant_d;

    logic        s4_valid_q, s4_valid_d;
    logic [31:0] s4_data_q, s4_data_d;

    always_comb begin
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);
        a_big  = s_a_tdata[30:0] >= s_b_tdata[30:0];
    end

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_spec_d     = s1_spec_q;
        s1_spec_val_d = s1_spec_val_q;
        s1_sign_d     = s1_sign_q;
        s1_sub_d      = s1_sub_q;
        s1_exp_d      = s1_exp_q;
        s1_diff_d     = s1_diff_q;
        s1_mbig_d     = s1_mbig_q;
        s1_msmall_d   = s1_msmall_q;
        if (advance) begin
            s1_valid_d    = take;
            s1_spec_d     = 1'b1;
            s1_spec_val_d = QNAN;
            if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
                s1_spec_val_d = QNAN;
            end else if (a_inf) begin
                s1_spec_val_d = {sa, 8'hFF, 23'd0};
            end else if (b_inf) begin
                s1_spec_val_d = {sb, 8'hFF, 23'd0};
            end else if (a_zero && b_zero) begin
                s1_spec_val_d = {sa & sb, 31'd0};
            end else if (a_zero) begin
                s1_spec_val_d = s_b_tdata;
            end else if (b_zero) begin
                s1_spec_val_d = s_a_tdata;
            end else begin
                s1_spec_d = 1'b0;
            end
            s1_sub_d = sa ^ sb;
            if (a_big) begin
                s1_sign_d   = sa;
                s1_exp_d    = ea;
                s1_diff_d   = ea - eb;
                s1_mbig_d   = {1'b1, fa};
                s1_msmall_d = {1'b1, fb};
            end else begin
                s1_sign_d   = sb;
                s1_exp_d    = eb;
                s1_diff_d   = eb - ea;
                s1_mbig_d   = {1'b1, fb};
                s1_msmall_d = {1'b1, fa};
            end
        end
    end

    logic [49:0] align_sh;

    always_comb begin
        s2_valid_d    = s2_valid_q;
        s2_spec_d     = s2_spec_q;
        s2_spec_val_d = s2_spec_val_q;
        s2_sign_d     = s2_sign_q;
        s2_sub_d      = s2_sub_q;
        s2_exp_d      = s2_exp_q;
        s2_mbig_d     = s2_mbig_q;
        s2_msmall_d   = s2_msmall_q;
        align_sh      = {s1_msmall_q, 26'd0} >> s1_diff_q;
        if (advance) begin
            s2_valid_d    = s1_valid_q;
            s2_spec_d     = s1_spec_q;
            s2_spec_val_d = s1_spec_val_q;
            s2_sign_d     = s1_sign_q;
            s2_sub_d      = s1_sub_q;
            s2_exp_d      = s1_exp_q;
            s2_mbig_d     = {s1_mbig_q, 3'b000};
            // beyond 25 positions the small operand only contributes to sticky
            s2_msmall_d   = (s1_diff_q >= 8'd26) ? 27'd1 : {align_sh[49:24], |align_sh[23:0]};
        end
    end

    logic [27:0] sum;
    logic [4:0]  lz;
    logic        lz_found;

    always_comb begin
        s3_valid_d    = s3_valid_q;
        s3_spec_d     = s3_spec_q;
        s3_spec_val_d = s3_spec_val_q;
        s3_sign_d     = s3_sign_q;
        s3_zero_d     = s3_zero_q;
        s3_exp_d      = s3_exp_q;
        s3_mant_d     = s3_mant_q;
        sum = s2_sub_q ? ({1'b0, s2_mbig_q} - {1'b0, s2_msmall_q})
                       : ({1'b0, s2_mbig_q} + {1'b0, s2_msmall_q});
        lz       = 5'd0;
        lz_found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!lz_found && sum[i]) begin
                lz       = 5'(26 - i);
                lz_found = 1'b1;
            end
        end
        if (advance) begin
            s3_valid_d    = s2_valid_q;
            s3_spec_d     = s2_spec_q;
            s3_spec_val_d = s2_spec_val_q;
            s3_sign_d     = s2_sign_q;
            s3_zero_d     = (sum == 28'd0);
            if (sum[27]) begin
                s3_mant_d = {sum[27:2], sum[1] | sum[0]};
                s3_exp_d  = {2'b00, s2_exp_q} + 10'd1;
            end else begin
                s3_mant_d = sum[26:0] << lz;
                s3_exp_d  = {2'b00, s2_exp_q} - {5'd0, lz};
            end
        end
    end

    logic        round_up;
    logic [24:0] mant_r;
    logic [9:0]  exp_r;

    always_comb begin
        s4_valid_d = s4_valid_q;
        s4_data_d  = s4_data_q;
        round_up   = s3_mant_q[2] & (s3_mant_q[1] | s3_mant_q[0] | s3_mant_q[3]);
        mant_r     = {1'b0, s3_mant_q[26:3]} + {24'd0, round_up};
        exp_r      = s3_exp_q + {9'd0, mant_r[24]};
        if (advance) begin
            s4_valid_d = s3_valid_q;
            if (s3_spec_q) begin
                s4_data_d = s3_spec_val_q;
            end else if (s3_zero_q) begin
                s4_data_d = 32'd0;
            end else if (s3_exp_q[9] || (s3_exp_q == 10'd0)) begin
                s4_data_d = {s3_sign_q, 31'd0};
            end else if (exp_r >= 10'd255) begin
                s4_data_d = {s3_sign_q, 8'hFF, 23'd0};
            end else begin
                s4_data_d = {s3_sign_q, exp_r[7:0], mant_r[22:0]};
            end
        end
    end

`ifdef PLS_FP_ADDER_SKID_EN
    logic        advance_q, advance_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic        push, pop;
    logic [1:0]  occ;

    // the enable is a registered prediction of free space, so the pipe never sees m_result_tready
    always_comb begin
        push      = s4_valid_q & advance_q;
        pop       = (count_q != 2'd0) & m_result_tready;
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
        occ       = count_q - {1'b0, pop};
        advance_d = (count_d != 2'd2);
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        if (pop) begin
            buf0_d = buf1_q;
        end
        if (push) begin
            if (occ == 2'd0) begin
                buf0_d = s4_data_q;
            end else begin
                buf1_d = s4_data_q;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            advance_q <= 1'b1;
            count_q   <= 2'd0;
            buf0_q    <= 32'd0;
            buf1_q    <= 32'd0;
        end else begin
            advance_q <= advance_d;
            count_q   <= count_d;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
        end
    end

    assign advance         = advance_q;
    assign m_result_tvalid = (count_q != 2'd0);
    assign m_result_tdata  = buf0_q;
`else
    assign advance         = ~s4_valid_q | m_result_tready;
    assign m_result_tvalid = s4_valid_q;
    assign m_result_tdata  = s4_data_q;
`endif

    assign take       = s_a_tvalid & s_b_tvalid & advance & ~areset;
    assign s_a_tready = take;
    assign s_b_tready = take;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s1_valid_q    <= 1'b0;
            s1_spec_q     <= 1'b0;
            s1_spec_val_q <= 32'd0;
            s1_sign_q     <= 1'b0;
            s1_sub_q      <= 1'b0;
            s1_exp_q      <= 8'd0;
            s1_diff_q     <= 8'd0;
            s1_mbig_q     <= 24'd0;
            s1_msmall_q   <= 24'd0;
            s2_valid_q    <= 1'b0;
            s2_spec_q     <= 1'b0;
            s2_spec_val_q <= 32'd0;
            s2_sign_q     <= 1'b0;
            s2_sub_q      <= 1'b0;
            s2_exp_q      <= 8'd0;
            s2_mbig_q     <= 27'd0;
            s2_msmall_q   <= 27'd0;
            s3_valid_q    <= 1'b0;
            s3_spec_q     <= 1'b0;
            s3_spec_val_q <= 32'd0;
            s3_sign_q     <= 1'b0;
            s3_zero_q     <= 1'b0;
            s3_exp_q      <= 10'd0;
            s3_mant_q     <= 27'd0;
            s4_valid_q    <= 1'b0;
            s4_data_q     <= 32'd0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_spec_q     <= s1_spec_d;
            s1_spec_val_q <= s1_spec_val_d;
            s1_sign_q     <= s1_sign_d;
            s1_sub_q      <= s1_sub_d;
            s1_exp_q      <= s1_exp_d;
            s1_diff_q     <= s1_diff_d;
            s1_mbig_q     <= s1_mbig_d;
            s1_msmall_q   <= s1_msmall_d;
            s2_valid_q    <= s2_valid_d;
            s2_spec_q     <= s2_spec_d;
            s2_spec_val_q <= s2_spec_val_d;
            s2_sign_q     <= s2_sign_d;
            s2_sub_q      <= s2_sub_d;
            s2_exp_q      <= s2_exp_d;
            s2_mbig_q     <= s2_mbig_d;
            s2_msmall_q   <= s2_msmall_d;
            s3_valid_q    <= s3_valid_d;
            s3_spec_q     <= s3_spec_d;
            s3_spec_val_q <= s3_spec_val_d;
            s3_sign_q     <= s3_sign_d;
            s3_zero_q     <= s3_zero_d;
            s3_exp_q      <= s3_exp_d;
            s3_mant_q     <= s3_mant_d;
            s4_valid_q    <= s4_valid_d;
            s4_data_q     <= s4_data_d;
        end
    end

endmodule

// File: tb/tb_pls_fp_adder.sv
// tb/tb_pls_fp_adder.sv - scoreboard bench for pls_fp_adder with directed vectors
module tb_pls_fp_adder;

`ifdef PLS_FP_ADDER_SKID_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic        aclk;
    logic        areset;
    logic [31:0] s_a_tdata, s_b_tdata, m_result_tdata;
    logic        s_a_tvalid, s_a_tready, s_b_tvalid, s_b_tready;
    logic        m_result_tvalid, m_result_tready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs = 0;
    int rel = 0;
    int n = 0;
    logic chk_lat = 1'b1;
    logic [31:0] exp_q[$];
    int          hs_q[$];

    pls_fp_adder #(.DATA_SIZE(32)) dut (
        .aclk(aclk),
        .areset(areset),
        .s_a_tdata(s_a_tdata),
        .s_a_tvalid(s_a_tvalid),
        .s_a_tready(s_a_tready),
        .s_b_tdata(s_b_tdata),
        .s_b_tvalid(s_b_tvalid),
        .s_b_tready(s_b_tready),
        .m_result_tdata(m_result_tdata),
        .m_result_tvalid(m_result_tvalid),
        .m_result_tready(m_result_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] int_to_fp(input int v);
        int p;
        logic [31:0] m;
        p = 0;
        for (int i = 0; i < 31; i++) if ((v >> i) & 1) p = i;
        m = 32'(v) << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        int k;
        k = 0;
        s_a_tdata  = a;
        s_b_tdata  = b;
        s_a_tvalid = 1'b1;
        s_b_tvalid = 1'b1;
        @(negedge aclk);
        while (!(s_a_tready && s_b_tready) && k < 300) begin
            @(negedge aclk);
            k++;
        end
        if (k >= 300) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no handshake expected handshake for %h+%h", a, b);
        end else begin
            exp_q.push_back(e);
            hs_q.push_back(cyc);
            last_hs = cyc;
        end
        @(posedge aclk);
        #1;
        s_a_tvalid = 1'b0;
        s_b_tvalid = 1'b0;
    endtask

    task automatic monitor();
        logic [31:0] held;
        logic        held_v;
        logic [31:0] e;
        int          h;
        held_v = 1'b0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                held_v = 1'b0;
            end else begin
                if (held_v && m_result_tvalid) expect_eq("stall_stable", m_result_tdata, held);
                held_v = 1'b0;
                if (m_result_tvalid && !m_result_tready) begin
                    held   = m_result_tdata;
                    held_v = 1'b1;
                end
                if (m_result_tvalid && m_result_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %h expected no result", m_result_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        h = hs_q.pop_front();
                        expect_eq("result", m_result_tdata, e);
                        if (chk_lat) expect_eq("latency", 32'(cyc - h), 32'(LAT));
                    end
                end
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge aclk);
            k++;
        end
        expect_eq("drain", 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    initial begin
        areset          = 1'b1;
        s_a_tdata       = 32'h3F800000;
        s_b_tdata       = 32'h40000000;
        s_a_tvalid      = 1'b1;
        s_b_tvalid      = 1'b1;
        m_result_tready = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) @(posedge aclk);
        #1;
        expect_eq("rst_tvalid", {31'd0, m_result_tvalid}, 32'd0);
        expect_eq("rst_a_tready", {31'd0, s_a_tready}, 32'd0);
        expect_eq("rst_b_tready", {31'd0, s_b_tready}, 32'd0);
        expect_eq("rst_tdata", m_result_tdata, 32'd0);
        s_a_tvalid = 1'b0;
        s_b_tvalid = 1'b0;
        areset     = 1'b0;

        send(32'h3F800000, 32'h40000000, 32'h40400000);
        send(32'h3F800000, 32'h33800000, 32'h3F800000);
        send(32'h3F800000, 32'h33800001, 32'h3F800001);
        send(32'h3F800001, 32'h33800000, 32'h3F800002);
        send(32'h3F800000, 32'hBF800000, 32'h00000000);
        send(32'h7F800000, 32'hFF800000, 32'h7FC00000);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        send(32'h7F7FFFFF, 32'h73000000, 32'h7F800000);
        send(32'h80000000, 32'h80000000, 32'h80000000);
        send(32'h00000000, 32'h80000000, 32'h00000000);
        send(32'hFF800000, 32'h3F800000, 32'hFF800000);
        send(32'h7FC00001, 32'h3F800000, 32'h7FC00000);
        send(32'h00000001, 32'h80000000, 32'h00000000);
        send(32'h3F800000, 32'hBF400000, 32'h3E800000);
        send(32'h00800000, 32'h80800001, 32'h80000000);
        send(32'h00400000, 32'h40000000, 32'h40000000);
        drain();

        s_a_tdata  = 32'h40000000;
        s_a_tvalid = 1'b1;
        s_b_tvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            expect_eq("a_only_a_tready", {31'd0, s_a_tready}, 32'd0);
            expect_eq("a_only_b_tready", {31'd0, s_b_tready}, 32'd0);
        end
        @(posedge aclk);
        #1;
        rel = cyc;
        send(32'h40000000, 32'h3F800000, 32'h40400000);
        expect_eq("join_accept", 32'(last_hs), 32'(rel));
        drain();

        chk_lat = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++)
                    send(int_to_fp(i + 1), int_to_fp(2 * i + 3), int_to_fp(3 * i + 4));
            end
            begin
                repeat (8) @(posedge aclk);
                #1 m_result_tready = 1'b0;
                repeat (10) @(posedge aclk);
                #1 m_result_tready = 1'b1;
            end
        join
        drain();
        chk_lat = 1'b1;

        send(32'h3F800000, 32'h3F800000, 32'h40000000);
        send(32'h40000000, 32'h3F800000, 32'h40400000);
        send(32'h40400000, 32'h3F800000, 32'h40800000);
        areset = 1'b1;
        #1;
        expect_eq("midrst_tvalid", {31'd0, m_result_tvalid}, 32'd0);
        expect_eq("midrst_tready", {31'd0, s_a_tready}, 32'd0);
        expect_eq("midrst_tdata", m_result_tdata, 32'd0);
        exp_q.delete();
        hs_q.delete();
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        rel    = cyc;
        send(32'h40000000, 32'h40000000, 32'h40800000);
        expect_eq("first_edge_accept", 32'(last_hs), 32'(rel));
        drain();
        n = 0;
        repeat (10) begin
            @(negedge aclk);
            if (m_result_tvalid) n++;
        end
        expect_eq("no_stale", 32'(n), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
